// File: rtl/sram_pkg.sv
// Shared types and constants for the 32-bit-over-16-bit SRAM controller.
package sram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi,
    StDone
  } state_e;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;

  // Word select bits in the byte address and half select bit in the SRAM address.
  localparam int unsigned WORD_LSB     = 2;
  localparam int unsigned WORD_MSB     = 18;
  localparam int unsigned HALF_SEL_BIT = 0;

  function automatic logic [SRAM_ADDR_W-1:0] half_addr(
    input logic [WORD_MSB-WORD_LSB:0] word,
    input logic                       hi
  );
    return {word, 1'b0} | (SRAM_ADDR_W'(hi) << HALF_SEL_BIT);
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase cycle counter; `last` flags the final cycle of a WAIT_CYCLES-long phase.
module sram_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int unsigned CntW = $clog2(WAIT_CYCLES);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign last = (r_cnt == CntW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_mem_ctrl.sv
// MEM-stage responder: each 32-bit request runs as a low then high 16-bit SRAM access,
// stalling the pipeline through `ready` until the word completes.
module sram_mem_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  state_e                 r_state, w_state_next;
  logic                   r_is_write;
  logic [31:0]            r_read_data;
  logic [SRAM_ADDR_W-1:0] r_sram_addr, w_addr_live;
  logic [SRAM_DATA_W-1:0] r_dq_out, w_dq_live;
  logic                   w_start, w_active, w_hi, w_last, w_clr;
  logic                   w_unused_addr;

  assign w_start       = (r_state == StIdle) && (wr_en || rd_en);
  assign w_active      = (r_state == StLo) || (r_state == StHi);
  assign w_hi          = (r_state == StHi);
  // Address and data follow the inputs live; only the operation type is latched.
  assign w_addr_live   = half_addr(address[WORD_MSB:WORD_LSB], w_hi);
  assign w_dq_live     = w_hi ? write_data[31:16] : write_data[15:0];
  assign w_unused_addr = ^{address[31:WORD_MSB+1], address[WORD_LSB-1:0]};

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .en  (w_active),
    .last(w_last)
  );

  always_comb begin
    w_state_next = r_state;
    w_clr        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_next = StLo;
          w_clr        = 1'b1;
        end
      end
      StLo: begin
        if (w_last) begin
          w_state_next = StHi;
          w_clr        = 1'b1;
        end
      end
      StHi: begin
        if (w_last) begin
          w_state_next = StDone;
          w_clr        = 1'b1;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_is_write  <= 1'b0;
      r_read_data <= '0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_is_write <= wr_en;
      end
      if (w_active) begin
        r_sram_addr <= w_addr_live;
        r_dq_out    <= w_dq_live;
      end
      if (w_active && !r_is_write && w_last) begin
        if (w_hi) begin
          r_read_data[31:16] <= sram_dq_in;
        end else begin
          r_read_data[15:0] <= sram_dq_in;
        end
      end
    end
  end

  assign read_data   = r_read_data;
  assign ready       = (r_state == StDone) || ((r_state == StIdle) && !rd_en && !wr_en);
  assign sram_addr   = w_active ? w_addr_live : r_sram_addr;
  assign sram_dq_out = w_active ? w_dq_live : r_dq_out;
  assign sram_dq_oe  = w_active && r_is_write;
  // Strobe released in the phase's last cycle so address/data outlast its rising edge.
  assign sram_we_n   = !(w_active && r_is_write && !w_last);

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: SRAM model, table of word transactions with a read_data
// scoreboard, plus reset-mid-write, back-to-back and WAIT_CYCLES=4 sequences.
module tb_sram_mem_ctrl;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  logic        rd4, wr4;
  logic [31:0] address4, write_data4, read_data4;
  logic        ready4;
  logic [17:0] sram_addr4;
  logic [15:0] sram_dq_out4, sram_dq_in4;
  logic        sram_dq_oe4, sram_we_n4;

  logic [15:0] mem [0:255];
  logic        mem_load;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  sram_mem_ctrl #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
    .sram_we_n(sram_we_n)
  );

  sram_mem_ctrl #(.WAIT_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .rd_en(rd4), .wr_en(wr4), .address(address4),
    .write_data(write_data4), .read_data(read_data4), .ready(ready4),
    .sram_addr(sram_addr4), .sram_dq_out(sram_dq_out4), .sram_dq_in(sram_dq_in4),
    .sram_dq_oe(sram_dq_oe4), .sram_we_n(sram_we_n4)
  );

  // Half-word i initially holds {i, ~i}.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= {8'(i), ~8'(i)};
    end else if (sram_dq_oe && !sram_we_n) begin
      mem[sram_addr[7:0]] <= sram_dq_out;
    end
  end
  assign sram_dq_in  = mem[sram_addr[7:0]];
  assign sram_dq_in4 = sram_addr4[0] ? 16'hCAFE : 16'hF00D;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Wait for ready at the DONE cycle (bounded), then compare against the scoreboard.
  task automatic finish_txn(input string name, input int w, input bit use4);
    int n;
    logic [31:0] exp;
    @(negedge clk);
    n = 0;
    while (!(use4 ? ready4 : ready) && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_cycle_offset"}, n, 0);
    exp = exp_q.pop_front();
    chk({name, "_read_data"}, use4 ? read_data4 : read_data, exp);
    if (w < 0) $display("unused");
  endtask

  // Called just after a rising edge; returns just after the edge that leaves DONE.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd);
    rd_en      = rd;
    wr_en      = wr;
    address    = addr;
    write_data = wdata;
    exp_q.push_back(exp_rd);
    @(negedge clk);
    chk("c0_ready", ready, 0);
    chk("c0_oe", sram_dq_oe, 0);
    chk("c0_we_n", sram_we_n, 1);
    for (int c = 1; c <= 2 * W; c++) begin
      logic hi;
      hi = (c > W);
      @(negedge clk);
      chk("ph_addr", sram_addr, {14'd0, addr[18:2], hi});
      chk("ph_oe", sram_dq_oe, wr);
      chk("ph_we_n", sram_we_n, !(wr && (((c - 1) % W) != W - 1)));
      if (wr) chk("ph_dq", sram_dq_out, hi ? wdata[31:16] : wdata[15:0]);
      chk("ph_ready", ready, 0);
    end
    finish_txn("txn", W, 1'b0);
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0404, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0404, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0408, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0408, 32'h0000_0000, 32'h1234_5678};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h01FE_00FF};
    vecs[5] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hAAAA_5555, 32'h01FE_00FF};
    vecs[6] = '{1'b1, 1'b0, 32'h0007_FFFC, 32'h0000_0000, 32'hAAAA_5555};

    rst = 1'b0; mem_load = 1'b1;
    rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    rd4 = 1'b0; wr4 = 1'b0; address4 = '0; write_data4 = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_oe", sram_dq_oe, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_dq_out", sram_dq_out, 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_read_data4", read_data4, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_load = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);
    end

    // Read then a write in the cycle right after DONE; read_data must survive the write.
    run_txn(1'b1, 1'b0, 32'h0000_0404, 32'h0, 32'hDEAD_BEEF);
    run_txn(1'b0, 1'b1, 32'h0000_0410, 32'h1111_2222, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("idle_ready", ready, 1);
    chk("idle_oe", sram_dq_oe, 0);
    chk("idle_addr_hold", sram_addr, 18'h209);
    chk("idle_dq_hold", sram_dq_out, 16'h1111);
    chk("b2b_read_data_kept", read_data, 32'hDEAD_BEEF);

    // Reset in cycle 3 of a write: low half stays written, high half untouched.
    @(posedge clk);
    #1;
    wr_en = 1'b1; address = 32'h0000_040C; write_data = 32'h0BAD_F00D;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    chk("mid_we_n_before", sram_we_n, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_we_n", sram_we_n, 1);
    chk("mid_rst_oe", sram_dq_oe, 0);
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", ready, 1);
    chk("post_rst_read_data", read_data, 0);
    @(posedge clk);
    #1;
    run_txn(1'b1, 1'b0, 32'h0000_040C, 32'h0, 32'h07F8_F00D);

    // WAIT_CYCLES = 4 read of address 0.
    rd4 = 1'b1;
    exp_q.push_back(32'hCAFE_F00D);
    @(negedge clk);
    chk("w4_c0_ready", ready4, 0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("w4_addr", sram_addr4, {17'd0, c > 4});
      chk("w4_oe", sram_dq_oe4, 0);
      chk("w4_we_n", sram_we_n4, 1);
      chk("w4_ready", ready4, 0);
    end
    finish_txn("w4", 4, 1'b1);
    @(posedge clk);
    #1;
    rd4 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_mem_ctrl.md
# sram_mem_ctrl

Memory-side responder for the MEM pipeline stage. It accepts the stage's 32-bit word read and write requests and runs each one as two 16-bit half-word accesses on an external asynchronous SRAM. It holds `ready` low until the access completes, and the pipeline freezes on `ready` low. It sits between the MEM stage outputs (`ALU_result` as the address, `mem_read`, `mem_write`, store data) and the board SRAM pins.

## Interface
Parameters:
- WAIT_CYCLES, 2, cycles per half-word access; legal range is 2 or more.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_en  in  1  word read request; held stable by the pipeline while `ready` is 0.
- wr_en  in  1  word write request; held stable while `ready` is 0.
- address  in  32  byte address; bits [1:0] ignored, bits [18:2] select the word.
- write_data  in  32  store data; held stable while `ready` is 0.
- read_data  out  32  last completed read word, registered.
- ready  out  1  0 = stall the pipeline; 1 = request complete or no request.
- sram_addr  out  18  half-word address on the SRAM pins.
- sram_dq_out  out  16  data driven to the SRAM.
- sram_dq_in  in  16  data returned from the SRAM.
- sram_dq_oe  out  1  1 = controller drives the DQ bus.
- sram_we_n  out  1  SRAM write strobe, active-low.

## Operation
States are IDLE, LO, HI and DONE.

- **IDLE**
  - If `wr_en` is 1 at the clock edge, latch a write and go to LO.
  - Else, if `rd_en` is 1, latch a read and go to LO.
  - Otherwise stay in IDLE.
  - When both requests are 1, the write wins.
- **LO** accesses the low half-word: `sram_addr = {address[18:2],1'b0}`, data is `write_data[15:0]`.
- **HI** accesses the high half-word: `sram_addr = {address[18:2],1'b1}`, data is `write_data[31:16]`.
- **Phase counter:** each of LO and HI lasts exactly WAIT_CYCLES cycles. The counter is cleared on phase entry.
- **Write phase**
  - `sram_dq_oe` is 1 for the whole phase.
  - `sram_we_n` is 0 for every cycle of the phase except the last, where it is 1. Data and address are therefore held one cycle past the strobe rising edge.
- **Read phase**
  - `sram_dq_oe` is 0 and `sram_we_n` is 1.
  - `sram_dq_in` is captured at the clock edge that ends the phase: into `read_data[15:0]` for LO, into `read_data[31:16]` for HI.
- **DONE** lasts one cycle, then unconditionally returns to IDLE.
- **read_data update rules**
  - `read_data` changes only while a read is in progress.
  - Writes never modify it.
  - It holds its value until the next read completes.
- **ready** is combinational:
  - 1 in DONE.
  - 1 in IDLE when `rd_en` and `wr_en` are both 0.
  - 0 otherwise.
- **Outside active phases:** `sram_dq_oe` = 0, `sram_we_n` = 1, and `sram_addr` / `sram_dq_out` hold their last values.

## Timing
- **Cycle numbering:** cycle 0 is the IDLE cycle in which the request is first seen, with `ready` = 0.
  - LO occupies cycles 1..W.
  - HI occupies cycles W+1..2W.
  - DONE is cycle 2W+1, with `ready` = 1 and `read_data` valid.
  - Total stall is 2W+1 cycles. With W = 2, DONE is at cycle 5.
- **Back-to-back requests:** the pipeline advances on DONE. A new request present in the following IDLE cycle starts a new transaction, so there is one IDLE cycle between transactions.
- **Reset values:** state IDLE, counter 0, `read_data` 0, `sram_addr` 0, `sram_dq_out` 0, `sram_dq_oe` 0, `sram_we_n` 1. `ready` follows the IDLE rule above.
- **Reset mid-transaction:** the strobe is released and the bus is tri-stated immediately (asynchronous). A partially written word is left as is; no rollback.
- **Requests changing while `ready` is 0:** a protocol violation. The latched operation type is kept, and address/data are taken live from the inputs.

## Structure
- **Package `sram_pkg`** holds:
  - the state enum (IDLE, LO, HI, DONE);
  - `SRAM_ADDR_W` = 18 and `SRAM_DATA_W` = 16;
  - the half-select bit positions.
- **Sub-module `sram_wait_counter`:** parameterised by WAIT_CYCLES, with inputs `clr` and `en` and output `last`.

## Test plan
1. Write 0xDEADBEEF to 0x404 with W = 2.
   - `sram_addr` = 0x202 with DQ 0xBEEF in cycles 1–2.
   - `sram_addr` = 0x203 with DQ 0xDEAD in cycles 3–4.
   - `sram_we_n` = 0 only in cycles 1 and 3.
   - `ready` = 1 in cycle 5.
2. Read 0x404 against an SRAM model holding the data from test 1: `read_data` = 0xDEADBEEF and `ready` = 1 in cycle 5; `sram_dq_oe` = 0 throughout.
3. `rd_en` and `wr_en` both 1 at 0x408 with data 0x12345678: a write is performed (`sram_we_n` pulses) and `read_data` is unchanged.
4. Assert `rst` low in cycle 3 of a write: `sram_we_n` goes to 1 and `sram_dq_oe` to 0 within the same cycle. After release, the state is IDLE and `ready` = 1 with no request.
5. Read, then a write presented in the cycle after DONE: exactly one IDLE cycle between the two transactions, and `read_data` is retained after the write.
6. WAIT_CYCLES = 4, read of 0x0: each phase lasts 4 cycles and `ready` = 1 first in cycle 9.
